sram_bus_arbiter: RTL and testbench

- Shares the 32 KiB system SRAM between two requesters: the Z80 CPU port and a host port used for debug, program loading and DMA-style access.
- The CPU normally has priority.
- Host accesses are single-beat transfers with a req/ack handshake, inserted when the CPU is off the bus.
- If the CPU requests while a host transfer is in progress, it is stalled via a wait signal until the transfer completes.

---
 rtl/sram_bus_arbiter_if.sv | 46 ++++
 rtl/sram_bus_arbiter.sv | 123 ++++++++++++
 tb/tb_sram_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its two requesters (CPU and host) and the SRAM.
// The arbiter connects through the slave modport; the requester/SRAM side uses master.
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_cs;
    logic              cpu_rd;
    logic              cpu_wr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_wait_n;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic [ADDR_W-1:0] sram_a;
    logic              sram_cs;
    logic              sram_oe;
    logic              sram_we;
    logic [DATA_W-1:0] sram_d_in;
    logic [DATA_W-1:0] sram_d_out;

    modport slave (
        input  cpu_addr, cpu_cs, cpu_rd, cpu_wr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata,
        input  sram_d_out,
        output cpu_rdata, cpu_wait_n,
        output host_ack, host_rdata,
        output sram_a, sram_cs, sram_oe, sram_we, sram_d_in
    );

    modport master (
        output cpu_addr, cpu_cs, cpu_rd, cpu_wr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata,
        output sram_d_out,
        input  cpu_rdata, cpu_wait_n,
        input  host_ack, host_rdata,
        input  sram_a, sram_cs, sram_oe, sram_we, sram_d_in
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares the system SRAM between the Z80 CPU (normal priority) and a single-beat host port,
// with a starvation guard that hands the host the bus after it waited through a CPU ownership.
module sram_bus_arbiter #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    sram_bus_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CPU       = 2'd1,
        HOST_ACC  = 2'd2,
        HOST_DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              starve_q, starve_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

    logic              cpu_req;
    logic              host_ack;
    logic [ADDR_W-1:0] sram_a;
    logic              sram_cs;
    logic              sram_oe;
    logic              sram_we;
    logic [DATA_W-1:0] sram_d_in;

    assign cpu_req = bus.cpu_cs & (bus.cpu_rd | bus.cpu_wr);

    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        host_rdata_d = host_rdata_q;
        sram_a       = '0;
        sram_cs      = 1'b0;
        sram_oe      = 1'b0;
        sram_we      = 1'b0;
        sram_d_in    = '0;
        host_ack     = 1'b0;

        case (state_q)
            IDLE: begin
                // A starved host beats a simultaneous CPU request; otherwise the CPU wins.
                if (bus.host_req && (!cpu_req || starve_q)) begin
                    state_d = HOST_ACC;
                end else if (cpu_req) begin
                    state_d = CPU;
                end
            end

            CPU: begin
                sram_a    = bus.cpu_addr;
                sram_cs   = 1'b1;
                sram_oe   = bus.cpu_rd;
                sram_we   = bus.cpu_wr;
                sram_d_in = bus.cpu_wdata;
                if (bus.host_req) begin
                    starve_d = 1'b1;
                end
                if (!cpu_req) begin
                    state_d = IDLE;
                end
            end

            HOST_ACC: begin
                sram_a    = bus.host_addr;
                sram_cs   = 1'b1;
                sram_oe   = !bus.host_we;
                sram_we   = bus.host_we;
                sram_d_in = bus.host_wdata;
                state_d   = HOST_DONE;
            end

            HOST_DONE: begin
                // Read data from the access cycle arrives now (1-cycle synchronous SRAM).
                host_ack = 1'b1;
                starve_d = 1'b0;
                if (!bus.host_we) begin
                    host_rdata_d = bus.sram_d_out;
                end
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase

        // Reset takes effect on the outputs immediately so an aborted transfer never acks.
        if (reset) begin
            sram_a    = '0;
            sram_cs   = 1'b0;
            sram_oe   = 1'b0;
            sram_we   = 1'b0;
            sram_d_in = '0;
            host_ack  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            starve_q     <= 1'b0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign bus.sram_a     = sram_a;
    assign bus.sram_cs    = sram_cs;
    assign bus.sram_oe    = sram_oe;
    assign bus.sram_we    = sram_we;
    assign bus.sram_d_in  = sram_d_in;
    assign bus.host_ack   = host_ack;
    assign bus.host_rdata = host_rdata_q;
    assign bus.cpu_rdata  = (state_q == CPU) ? bus.sram_d_out : '1;
    assign bus.cpu_wait_n = reset | !(cpu_req && (state_q != CPU));

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: SRAM array model, transaction-level ownership model checked every
// cycle, and directed scenarios with hand-computed expectations.
module tb_sram_bus_arbiter;
    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] pat(input int a);
        if (a == 32'h0123) return 8'h5A;
        return 8'((a * 7 + 3) & 255);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // SRAM device: 1-cycle synchronous read, write on the clock edge.
    logic [7:0] sram [0:32767];
    initial begin : sram_dev
        for (int i = 0; i < 32768; i++) sram[i] <= pat(i);
        bus.sram_d_out <= '0;
        forever begin
            @(posedge clk);
            if (bus.sram_cs && bus.sram_we) sram[bus.sram_a] <= bus.sram_d_in;
            if (bus.sram_cs && bus.sram_oe) bus.sram_d_out <= sram[bus.sram_a];
        end
    end

    // Host protocol: host_req may only fall after an ack.
    logic req_prev = 1'b0;
    logic ack_prev = 1'b0;
    always @(negedge clk) begin
        if (!reset && req_prev && !bus.host_req)
            assert (ack_prev) else $error("host_req withdrawn before host_ack");
        req_prev <= bus.host_req;
        ack_prev <= bus.host_ack;
    end

    // Ownership model: who holds the bus, how far a host transfer has got, and the starve flag.
    bit          m_cpu    = 1'b0;
    int          m_step   = 0;
    bit          m_starve = 1'b0;
    logic [7:0]  m_last   = 8'h00;
    logic [7:0]  m_hrd    = 8'h00;
    logic [7:0]  m_mem [0:32767];
    logic        e_creq, e_cs, e_oe, e_we, e_ack, e_wait;
    logic [14:0] e_a;
    logic [7:0]  e_din, e_crd;

    initial begin : model
        for (int i = 0; i < 32768; i++) m_mem[i] = pat(i);
        forever begin
            @(negedge clk);
            if (mon_en) begin
                e_creq = bus.cpu_cs & (bus.cpu_rd | bus.cpu_wr);
                e_a = '0; e_cs = 0; e_oe = 0; e_we = 0; e_din = '0; e_ack = 0;
                if (!reset) begin
                    if (m_cpu) begin
                        e_a = bus.cpu_addr; e_cs = 1; e_oe = bus.cpu_rd;
                        e_we = bus.cpu_wr; e_din = bus.cpu_wdata;
                    end else if (m_step == 1) begin
                        e_a = bus.host_addr; e_cs = 1; e_oe = !bus.host_we;
                        e_we = bus.host_we; e_din = bus.host_wdata;
                    end else if (m_step == 2) begin
                        e_ack = 1;
                    end
                end
                e_wait = reset | !(e_creq && !m_cpu);
                e_crd  = m_cpu ? m_last : 8'hFF;

                chk("sram_a",     32'(bus.sram_a),     32'(e_a));
                chk("sram_cs",    32'(bus.sram_cs),    32'(e_cs));
                chk("sram_oe",    32'(bus.sram_oe),    32'(e_oe));
                chk("sram_we",    32'(bus.sram_we),    32'(e_we));
                chk("sram_d_in",  32'(bus.sram_d_in),  32'(e_din));
                chk("host_ack",   32'(bus.host_ack),   32'(e_ack));
                chk("host_rdata", 32'(bus.host_rdata), 32'(m_hrd));
                chk("cpu_wait_n", 32'(bus.cpu_wait_n), 32'(e_wait));
                chk("cpu_rdata",  32'(bus.cpu_rdata),  32'(e_crd));

                if (e_cs && e_oe) m_last = m_mem[e_a];
                if (e_cs && e_we) m_mem[e_a] = e_din;
                if (reset) begin
                    m_cpu = 0; m_step = 0; m_starve = 0; m_hrd = 8'h00;
                end else if (m_cpu) begin
                    if (bus.host_req) m_starve = 1;
                    if (!e_creq) m_cpu = 0;
                end else if (m_step == 1) begin
                    m_step = 2;
                end else if (m_step == 2) begin
                    m_step = 0;
                    m_starve = 0;
                    if (!bus.host_we) m_hrd = m_last;
                end else if (bus.host_req && (!e_creq || m_starve)) begin
                    m_step = 1;
                end else if (e_creq) begin
                    m_cpu = 1;
                end
            end
        end
    end

    task automatic host_xfer(input bit we, input logic [14:0] a, input logic [7:0] d,
                             output int lat, output logic [7:0] rdat);
        bus.host_req = 1'b1; bus.host_we = we; bus.host_addr = a; bus.host_wdata = d;
        lat = -1;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus.host_ack && lat < 12);
        @(posedge clk); #1;
        bus.host_req = 1'b0;
        @(negedge clk);
        rdat = bus.host_rdata;
        @(posedge clk); #1;
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          lat, waits, n, we_cnt, prev_ack;
        bit          drop;
        logic [7:0]  r, crd;
        logic [15:0] wv, av;

        bus.cpu_addr = '0; bus.cpu_cs = 0; bus.cpu_rd = 0; bus.cpu_wr = 0; bus.cpu_wdata = '0;
        bus.host_req = 0; bus.host_we = 0; bus.host_addr = '0; bus.host_wdata = '0;
        reset = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(negedge clk);
        chk("rst_host_ack",   32'(bus.host_ack),   32'd0);
        chk("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
        chk("rst_wait_n",     32'(bus.cpu_wait_n), 32'd1);
        chk("rst_strobes",    32'({bus.sram_cs, bus.sram_oe, bus.sram_we}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // CPU read of 0x0123 for 4 cycles.
        bus.cpu_addr = 15'h0123; bus.cpu_cs = 1; bus.cpu_rd = 1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k >= 1 && k <= 3) chk("t1_wait_n", 32'(bus.cpu_wait_n), 32'd1);
            if (k == 2 || k == 3) chk("t1_cpu_rdata", 32'(bus.cpu_rdata), 32'h5A);
            chk("t1_no_ack", 32'(bus.host_ack), 32'd0);
            @(posedge clk); #1;
            if (k == 3) begin bus.cpu_cs = 0; bus.cpu_rd = 0; end
        end

        // Host write then read-back of 0x7FFF.
        host_xfer(1'b1, 15'h7FFF, 8'hC3, lat, r);
        chk("t2_wr_latency", 32'(lat), 32'd2);
        host_xfer(1'b0, 15'h7FFF, 8'h00, lat, r);
        chk("t2_rd_latency", 32'(lat), 32'd2);
        chk("t2_rd_data", 32'(r), 32'hC3);

        // CPU read arrives while a host write is in HOST_ACC.
        bus.host_req = 1; bus.host_we = 1; bus.host_addr = 15'h0200; bus.host_wdata = 8'hE7;
        @(posedge clk); #1;
        bus.cpu_cs = 1; bus.cpu_rd = 1; bus.cpu_addr = 15'h0200;
        waits = 0; drop = 0; crd = 8'h00;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (!bus.cpu_wait_n) waits++;
            if (k == 4) crd = bus.cpu_rdata;
            if (bus.host_ack) drop = 1;
            @(posedge clk); #1;
            if (drop) bus.host_req = 0;
        end
        bus.cpu_cs = 0; bus.cpu_rd = 0;
        @(posedge clk); #1;
        chk("t3_wait_cycles", 32'(waits), 32'd3);
        chk("t3_cpu_rdata", 32'(crd), 32'hE7);

        // Simultaneous requests: CPU first, then the starved host, then starve cleared.
        for (int k = 0; k < 16; k++) begin
            case (k)
                0: begin
                    bus.cpu_cs = 1; bus.cpu_rd = 1; bus.cpu_addr = 15'h0010;
                    bus.host_req = 1; bus.host_we = 0; bus.host_addr = 15'h0300;
                end
                4, 11:   begin bus.cpu_cs = 0; bus.cpu_rd = 0; end
                5:       begin bus.cpu_cs = 1; bus.cpu_rd = 1; end
                15:      bus.host_req = 0;
                default: ;
            endcase
            @(negedge clk);
            wv[k] = bus.cpu_wait_n;
            av[k] = bus.host_ack;
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("t4_wait_n_trace", 32'(wv), 32'h0000FE1E);
        chk("t4_ack_trace",    32'(av), 32'h00004080);
        chk("t4_host_rdata",   32'(bus.host_rdata), 32'h03);
        @(posedge clk); #1;

        // Reset during HOST_DONE of a read.
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 15'h0005;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t5_acc_oe", 32'(bus.sram_oe), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("t5_no_ack", 32'(bus.host_ack), 32'd0);
        @(posedge clk); #1;
        bus.host_req = 0;
        @(negedge clk);
        chk("t5_host_rdata", 32'(bus.host_rdata), 32'd0);
        chk("t5_strobes", 32'({bus.sram_cs, bus.sram_oe, bus.sram_we}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_idle_strobes", 32'({bus.sram_cs, bus.sram_oe, bus.sram_we}), 32'd0);
        chk("t5_idle_ack", 32'(bus.host_ack), 32'd0);
        @(posedge clk); #1;

        // 20 back-to-back host reads with host_req held high.
        bus.host_req = 1; bus.host_we = 0; bus.host_addr = 15'h0000;
        we_cnt = 0; prev_ack = 0;
        for (int j = 0; j < 20; j++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
                if (bus.sram_we) we_cnt++;
            end while (!bus.host_ack && n < 8);
            chk("t6_ack", 32'(bus.host_ack), 32'd1);
            if (j > 0) chk("t6_period", 32'(cyc - prev_ack), 32'd3);
            prev_ack = cyc;
            @(posedge clk); #1;
            if (j < 19) bus.host_addr = 15'(j + 1);
            else bus.host_req = 0;
            @(negedge clk);
            if (bus.sram_we) we_cnt++;
            chk("t6_rdata", 32'(bus.host_rdata), 32'(pat(j)));
        end
        chk("t6_no_sram_we", 32'(we_cnt), 32'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
